// File: rtl/bin2bcd_display.sv
// bin2bcd_display: converts a 32-bit unsigned binary value into 8 packed BCD digits for an
// 8-digit display, using the shift-and-add-3 (double dabble) algorithm one bit per clock.
//
// Parameters:
//   SATURATE - overflow result: 1 -> all digits 9, 0 -> all digits E
// Ports:
//   clock  - system clock, rising edge
//   resetn - asynchronous active-low reset
//   start  - conversion request, only looked at while idle
//   bin    - binary input, captured on the accepting edge
//   busy   - conversion in progress (SHIFT or FINISH)
//   done   - one-cycle pulse: bcd/blank/ovf were just updated
//   bcd    - packed BCD result, digit i = bcd[4i+3:4i]
//   blank  - bit i set when digit i is a leading zero (bit 0 never set)
//   ovf    - last accepted value exceeded 99_999_999
module bin2bcd_display #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd,
  output logic [7:0]  blank,
  output logic        ovf
);

  localparam logic [31:0] MaxVal   = 32'd99_999_999;
  localparam logic [31:0] OvfBcd   = SATURATE ? 32'h9999_9999 : 32'hEEEE_EEEE;
  localparam logic [4:0]  LastIter = 5'd26;

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [26:0] sr_q, sr_d;
  logic [31:0] acc_q, acc_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic        done_q, done_d;
  logic [31:0] bcd_q, bcd_d;
  logic [7:0]  blank_q, blank_d;
  logic        ovf_q, ovf_d;

  logic [31:0] acc_adj;
  logic [7:0]  blank_norm;
  logic        zero_above;

  // Add-3 correction on every digit that would exceed 9 after doubling.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 8; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask: digit i is blank when it and every higher digit are zero.
  always_comb begin
    blank_norm = 8'h00;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_above    = zero_above & (acc_q[4*i +: 4] == 4'd0);
      blank_norm[i] = zero_above;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (bin <= MaxVal) begin
            // Values in range fit in 27 bits, so only those bits need shifting.
            sr_d       = bin[26:0];
            acc_d      = 32'h0;
            cnt_d      = 5'd0;
            ovf_pend_d = 1'b0;
            state_d    = StShift;
          end else begin
            ovf_pend_d = 1'b1;
            state_d    = StFinish;
          end
        end
      end
      StShift: begin
        {acc_d, sr_d} = {acc_adj[30:0], sr_q, 1'b0};
        cnt_d         = cnt_q + 5'd1;
        if (cnt_q == LastIter) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        cnt_d   = 5'd0;
        state_d = StIdle;
        if (ovf_pend_q) begin
          bcd_d   = OvfBcd;
          blank_d = 8'h00;
          ovf_d   = 1'b1;
        end else begin
          bcd_d   = acc_q;
          blank_d = blank_norm;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      sr_q       <= 27'd0;
      acc_q      <= 32'h0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= 32'h0;
      blank_q    <= 8'hFE;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_display.sv
// Scoreboard bench for bin2bcd_display. A posedge model decides which starts are accepted and
// queues the expected result with its due cycle; a negedge monitor compares on every done.
// Two instances share the inputs to cover both SATURATE settings.
module tb_bin2bcd_display;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bin = 32'h0;
  logic        busy1, done1, ovf1, busy0, done0, ovf0;
  logic [31:0] bcd1, bcd0;
  logic [7:0]  blank1, blank0;

  bin2bcd_display #(.SATURATE(1'b1)) dut1 (
    .clock(clock), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .bcd(bcd1), .blank(blank1), .ovf(ovf1)
  );

  bin2bcd_display #(.SATURATE(1'b0)) dut0 (
    .clock(clock), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy0), .done(done0), .bcd(bcd0), .blank(blank0), .ovf(ovf0)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] bcd1;
    logic [31:0] bcd0;
    logic [7:0]  blank;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_from = 0;
  int acc_cyc = 0;
  int acc_lat = 0;
  exp_t last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division; digits i..7 are all zero exactly when b < 10^i.
  function automatic exp_t model(input logic [31:0] b, input int due);
    exp_t   e;
    longint p;
    longint v;
    e.due = due;
    v = longint'(b);
    if (v > 64'd99_999_999) begin
      e.bcd1  = 32'h9999_9999;
      e.bcd0  = 32'hEEEE_EEEE;
      e.blank = 8'h00;
      e.ovf   = 1'b1;
    end else begin
      e.bcd1  = 32'h0;
      e.blank = 8'h00;
      e.ovf   = 1'b0;
      p = 1;
      for (int i = 0; i < 8; i++) begin
        e.bcd1[4*i +: 4] = 4'((v / p) % 10);
        if (i > 0 && v < p) e.blank[i] = 1'b1;
        p = p * 10;
      end
      e.bcd0 = e.bcd1;
    end
    return e;
  endfunction

  function automatic exp_t reset_vals();
    exp_t e;
    e.bcd1 = 32'h0; e.bcd0 = 32'h0; e.blank = 8'hFE; e.ovf = 1'b0; e.due = 0;
    return e;
  endfunction

  // Acceptance model: a start is taken when out of reset and the previous job has left done.
  always @(posedge clock) begin
    int lat;
    cyc++;
    if (resetn && start && cyc >= idle_from) begin
      lat = (bin > 32'd99_999_999) ? 1 : 28;
      q.push_back(model(bin, cyc + lat));
      acc_cyc   = cyc;
      acc_lat   = lat;
      idle_from = cyc + lat + 1;
    end
  end

  // Monitor.
  always @(negedge clock) begin
    exp_t e;
    logic exp_busy;
    if (resetn) begin
      exp_busy = (acc_lat != 0) && (cyc >= acc_cyc) && (cyc < acc_cyc + acc_lat);
      chk("busy1", 32'(busy1), 32'(exp_busy));
      chk("busy0", 32'(busy0), 32'(exp_busy));
      if (q.size() != 0 && cyc > q[0].due) begin
        chk("missing_done", 32'(done1), 32'd1);
        void'(q.pop_front());
      end
      if (done1 || done0) begin
        chk("done_busy_excl", 32'(busy1 & done1), 32'd0);
        chk("done_pair", 32'(done0), 32'(done1));
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done1 | done0), 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.due));
          chk("bcd_sat1", bcd1, e.bcd1);
          chk("bcd_sat0", bcd0, e.bcd0);
          chk("blank", 32'(blank1), 32'(e.blank));
          chk("blank0", 32'(blank0), 32'(e.blank));
          chk("ovf", 32'(ovf1), 32'(e.ovf));
          chk("ovf0", 32'(ovf0), 32'(e.ovf));
          last = e;
        end
      end else begin
        chk("hold_bcd1", bcd1, last.bcd1);
        chk("hold_bcd0", bcd0, last.bcd0);
        chk("hold_blank", 32'(blank1), 32'(last.blank));
        chk("hold_ovf", 32'(ovf1), 32'(last.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(busy1 | busy0), 32'd0);
    chk("rst_done", 32'(done1 | done0), 32'd0);
    chk("rst_bcd1", bcd1, 32'h0);
    chk("rst_bcd0", bcd0, 32'h0);
    chk("rst_blank", 32'(blank1), 32'hFE);
    chk("rst_ovf", 32'(ovf1 | ovf0), 32'd0);
  endtask

  // Called just after a rising edge; checks outputs before any further edge, with start held.
  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    start  = 1'b1;
    bin    = 32'd55;
    q.delete();
    idle_from = 0;
    acc_lat   = 0;
    last      = reset_vals();
    #1;
    check_reset_outputs();
    repeat (cycles) begin
      tick();
      check_reset_outputs();
    end
    start  = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cyc < idle_from || q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic convert(input logic [31:0] v);
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = $urandom;
    wait_idle();
  endtask

  function automatic logic [31:0] gen();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 32'($urandom_range(0, 99_999_999));
      4:          return 32'($urandom_range(0, 999));
      5:          return 32'($urandom_range(0, 9));
      6:          return ($urandom_range(0, 1) != 0) ? 32'd99_999_999 : 32'd100_000_000;
      7:          return 32'($urandom_range(100_000_000, 32'hFFFF_FFFF));
      8:          return 32'($urandom_range(99_999_990, 100_000_010));
      default:    return $urandom;
    endcase
  endfunction

  initial begin
    last = reset_vals();
    tick();
    do_reset(3);
    tick();

    // Directed values, including the overflow boundary.
    convert(32'd0);
    convert(32'd12_345_678);
    convert(32'd5);
    convert(32'd1000);
    convert(32'd99_999_999);
    convert(32'd100_000_000);
    convert(32'hFFFF_FFFF);
    convert(32'd7);

    // Starts while busy are ignored.
    start = 1'b1; bin = 32'd42;
    tick();
    start = 1'b0; bin = 32'd7;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle();

    // Start held high: back-to-back conversions, bin changes after the first accept.
    start = 1'b1; bin = 32'd1;
    tick();
    bin = 32'd2;
    repeat (60) tick();
    start = 1'b0;
    wait_idle();

    // Reset mid-conversion, then a clean conversion afterwards.
    convert(32'd42);
    start = 1'b1; bin = 32'd77;
    tick();
    start = 1'b0;
    repeat (9) tick();
    do_reset(2);
    tick();
    convert(32'd77);

    // Random start pulses and bin noise every cycle.
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      bin   = gen();
      tick();
    end
    start = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
